bpm_link_tx_arbiter: RTL and testbench
======================================

Name: bpm_link_tx_arbiter

Overview:
- Shares one Aurora BPM link AXI-stream TX port between NUM_SRC packet sources, e.g. the test-pattern writer and the live BPM forwarder.
- Arbitrates round-robin at packet boundaries, so packets from different sources are never interleaved.
- Drains sources when the channel drops and closes stalled packets after a timeout.
- Reports per-packet status and a per-FA-cycle packet count.
- Sits between the packet writers and the Aurora core, in the Aurora user clock domain.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- TIMEOUT, 255, consecutive mid-packet cycles with granted tvalid low before the packet is forcibly closed (1..65535).
- FILL_WORD, 32'hDEADDEAD, data word emitted to close a timed-out packet.

Ports:
- auroraUserClk  in  1  clock.
- auroraUserReset_n  in  1  asynchronous active-low reset.
- auroraChannelUp  in  1  link up.
- auroraFAstrobe  in  1  start of FA cycle, one-cycle pulse.
- srcEnable  in  NUM_SRC  per-source arbitration enable.
- s_tdata  in  NUM_SRC*32  source data; source i occupies bits [32i+31:32i].
- s_tvalid  in  NUM_SRC  source valid.
- s_tlast  in  NUM_SRC  source end of packet.
- s_tready  out  NUM_SRC  source ready.
- m_tdata  out  32  link data.
- m_tvalid  out  1  link valid.
- m_tlast  out  1  link end of packet.
- m_tready  in  1  link ready.
- grantIndex  out  3  currently or last granted source.
- statusStrobe  out  1  one-cycle status pulse.
- statusCode  out  2  0=packet done, 1=FA overrun, 2=channel-down drop, 3=timeout.
- packetCount  out  16  packets completed since the last auroraFAstrobe.

Behaviour:
- Reset: asynchronous active-low. All outputs are 0. State is IDLE, grant = 0, round-robin pointer = NUM_SRC-1, timeout counter = 0.
- A request from source i = s_tvalid[i] && srcEnable[i].
- IDLE:
  - m_tvalid=0 and s_tready=0.
  - If auroraChannelUp and any request: pick the first requester searching from pointer+1 modulo NUM_SRC. Register it in grant and grantIndex, then go to PASS. This costs one cycle of arbitration latency.
  - Sources that are not enabled are never granted.
- PASS:
  - Zero-latency combinational path: m_tdata/m_tvalid/m_tlast follow s_*[grant]; s_tready[grant] = m_tready; all other s_tready are 0.
  - On a handshake with tlast=1: pointer <= grant, statusStrobe=1 with code 0, packetCount increments (saturating at 16'hFFFF), go to IDLE.
  - Timeout counter clears on every cycle with s_tvalid[grant]=1 and increments otherwise. When it reaches TIMEOUT, go to CLOSE.
  - If auroraChannelUp falls: go to DRAIN with code 2. This takes priority over timeout in the same cycle.
- CLOSE:
  - m_tdata=FILL_WORD, m_tvalid=1, m_tlast=1, all s_tready=0.
  - On m_tready: statusStrobe with code 3, pointer <= grant, go to DRAIN.
  - If the channel drops while in CLOSE: go to DRAIN with code 2, without emitting the word.
- DRAIN:
  - m_tvalid=0; s_tready[grant]=1, discarding data.
  - On a handshake with s_tlast[grant]=1: go to IDLE. No further strobe is issued and packetCount does not increment.
- auroraFAstrobe:
  - packetCount <= 0. It takes precedence over a same-cycle increment, which is then lost.
  - If the state is PASS or CLOSE, issue an extra statusStrobe with code 1. Arbitration is not disturbed.
  - If a code-0/2/3 strobe coincides with the FA strobe, the code-1 strobe is delayed by one cycle.
- A source whose srcEnable drops mid-packet keeps its grant until tlast; enable is only sampled in IDLE.
- grantIndex holds its value in IDLE. Width is 3 regardless of NUM_SRC, with unused upper bits 0.
- auroraChannelUp low in IDLE: no grant is issued and requests wait.

Test Plan:
- Single source, 4-word packet (A5BE0000, CAFE0001, BEEF0001, 00010001; tlast on word 4), m_tready=1 → words appear unchanged on m_*; strobe code 0; packetCount=1; grantIndex=0.
- Both sources continuously requesting 4-word packets → grants alternate 0,1,0,1; no interleaving; one idle cycle between packets; packetCount=4 after 4 packets.
- Source 1 stops tvalid after word 2 with TIMEOUT=8 → after 8 low cycles, DEADDEAD with tlast is emitted; code 3. Source 1 then resumes: words 3 and 4 are accepted and discarded with m_tvalid=0, and the next grant goes to source 0.
- Channel drops after word 1 of a 4-word packet → m_tvalid=0 immediately; code 2; remaining 3 words are drained. No grant is issued until channelUp returns.
- auroraFAstrobe mid-packet with packetCount=5 → packetCount=0, strobe code 1, packet completes normally and packetCount becomes 1. Strobe coinciding with a tlast handshake → code 0, then code 1 the next cycle.
- auroraUserReset_n asserted mid-packet with m_tready=0 → all outputs 0 asynchronously; after release the state is IDLE and the first grant goes to source 0.

Source files
------------

// File: rtl/bpm_link_tx_arbiter.sv
// Round-robin packet arbiter sharing one Aurora AXI-stream TX port between
// NUM_SRC sources. Grants change only at packet boundaries. Stalled packets
// are closed with FILL_WORD after TIMEOUT idle cycles. A source is drained
// when the channel drops. Per-packet status and a per-FA-cycle packet count
// are reported.
module bpm_link_tx_arbiter #(
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] FILL_WORD = 32'hDEADDEAD
) (
   input  logic                  auroraUserClk,
   input  logic                  auroraUserReset_n,
   input  logic                  auroraChannelUp,
   input  logic                  auroraFAstrobe,
   input  logic [NUM_SRC-1:0]    srcEnable,
   input  logic [NUM_SRC*32-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]    s_tvalid,
   input  logic [NUM_SRC-1:0]    s_tlast,
   output logic [NUM_SRC-1:0]    s_tready,
   output logic [31:0]           m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic [2:0]            grantIndex,
   output logic                  statusStrobe,
   output logic [1:0]            statusCode,
   output logic [15:0]           packetCount
);

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_CLOSE, S_DRAIN} state_t;

   state_t               state, state_nxt;
   logic [2:0]           grant, ptr, pick;
   logic                 found;
   logic [15:0]          tcnt;
   logic [16:0]          tcnt_inc;
   logic                 fa_pending;
   logic [NUM_SRC-1:0]   req, g_onehot;
   logic                 g_valid, g_last;
   logic [31:0]          g_data;
   logic                 ev, done, ptr_load;
   logic [1:0]           ev_code;
   logic                 fa_hit;

   assign req        = s_tvalid & srcEnable;
   assign grantIndex = grant;
   assign tcnt_inc   = {1'b0, tcnt} + 17'd1;
   assign fa_hit     = auroraFAstrobe && (state == S_PASS || state == S_CLOSE);

   // Round-robin search starting one past the last completed grant
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         idx = (32'(ptr) + k) % NUM_SRC;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = 3'(idx);
         end
      end
   end

   // Select the granted source's stream signals
   always_comb begin
      g_valid  = 1'b0;
      g_last   = 1'b0;
      g_data   = '0;
      g_onehot = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant == 3'(i)) begin
            g_valid     = s_tvalid[i];
            g_last      = s_tlast[i];
            g_data      = s_tdata[32*i +: 32];
            g_onehot[i] = 1'b1;
         end
      end
   end

   // Next state, datapath muxing and status events
   always_comb begin
      state_nxt = state;
      m_tdata   = '0;
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      s_tready  = '0;
      ev        = 1'b0;
      ev_code   = 2'd0;
      done      = 1'b0;
      ptr_load  = 1'b0;
      case (state)
         S_IDLE: begin
            if (auroraChannelUp && found) state_nxt = S_PASS;
         end
         S_PASS: begin
            // The stream is blocked in the cycle the channel drops, so that
            // beat is left to the drain rather than being sent to a dead link.
            if (!auroraChannelUp) begin
               state_nxt = S_DRAIN;
               ev        = 1'b1;
               ev_code   = 2'd2;
            end else begin
               m_tdata  = g_data;
               m_tvalid = g_valid;
               m_tlast  = g_last;
               s_tready = g_onehot & {NUM_SRC{m_tready}};
               if (g_valid && m_tready && g_last) begin
                  state_nxt = S_IDLE;
                  ev        = 1'b1;
                  ev_code   = 2'd0;
                  done      = 1'b1;
                  ptr_load  = 1'b1;
               end else if (!g_valid && tcnt_inc >= 17'(TIMEOUT)) begin
                  state_nxt = S_CLOSE;
               end
            end
         end
         S_CLOSE: begin
            if (!auroraChannelUp) begin
               state_nxt = S_DRAIN;
               ev        = 1'b1;
               ev_code   = 2'd2;
            end else begin
               m_tdata  = FILL_WORD;
               m_tvalid = 1'b1;
               m_tlast  = 1'b1;
               if (m_tready) begin
                  state_nxt = S_DRAIN;
                  ev        = 1'b1;
                  ev_code   = 2'd3;
                  ptr_load  = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            s_tready = g_onehot;
            if (g_valid && g_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, grant, pointer and timeout counter registers
   always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
      if (!auroraUserReset_n) begin
         state <= S_IDLE;
         grant <= '0;
         ptr   <= 3'(NUM_SRC - 1);
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && state_nxt == S_PASS) grant <= pick;
         if (ptr_load) ptr <= grant;
         if (state != S_PASS || g_valid) tcnt <= '0;
         else                            tcnt <= tcnt_inc[15:0];
      end
   end

   // Status strobe, deferred FA report and packet counter
   always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
      if (!auroraUserReset_n) begin
         statusStrobe <= 1'b0;
         statusCode   <= '0;
         fa_pending   <= 1'b0;
         packetCount  <= '0;
      end else begin
         if (ev) begin
            statusStrobe <= 1'b1;
            statusCode   <= ev_code;
            fa_pending   <= fa_pending | fa_hit;
         end else if (fa_hit || fa_pending) begin
            statusStrobe <= 1'b1;
            statusCode   <= 2'd1;
            fa_pending   <= 1'b0;
         end else begin
            statusStrobe <= 1'b0;
         end
         if (auroraFAstrobe)                        packetCount <= '0;
         else if (done && packetCount != 16'hFFFF) packetCount <= packetCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_bpm_link_tx_arbiter.sv
// Directed scoreboard bench for bpm_link_tx_arbiter (NUM_SRC=2, TIMEOUT=8).
module tb_bpm_link_tx_arbiter;
   localparam int unsigned NS = 2;
   localparam int unsigned TO = 8;

   logic              clk = 1'b0;
   logic              rst_n, chan, fa, m_tready;
   logic [NS-1:0]     en, s_tvalid, s_tlast, s_tready;
   logic [NS*32-1:0]  s_tdata;
   logic [31:0]       m_tdata;
   logic              m_tvalid, m_tlast;
   logic [2:0]        grant_index;
   logic              status_strobe;
   logic [1:0]        status_code;
   logic [15:0]       packet_count;

   always #5 clk = ~clk;

   bpm_link_tx_arbiter #(.NUM_SRC(NS), .TIMEOUT(TO), .FILL_WORD(32'hDEADDEAD)) dut (
      .auroraUserClk(clk), .auroraUserReset_n(rst_n), .auroraChannelUp(chan),
      .auroraFAstrobe(fa), .srcEnable(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tlast(m_tlast), .m_tready(m_tready), .grantIndex(grant_index),
      .statusStrobe(status_strobe), .statusCode(status_code), .packetCount(packet_count)
   );

   logic [32:0] q0[$];      // source 0 words {last,data}
   logic [32:0] q1[$];      // source 1 words {last,data}
   logic [35:0] exp_q[$];   // expected link beats {src,last,data}
   logic [1:0]  stat_q[$];  // expected status codes in order
   int checks = 0, errors = 0;
   int cyc = 0, beats = 0;
   int last_beat_cyc = 0, prev_beat_cyc = 0;
   int last_strobe_cyc = 0, prev_strobe_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic present();
      s_tvalid[0]    = q0.size() > 0;
      s_tdata[31:0]  = (q0.size() > 0) ? q0[0][31:0] : '0;
      s_tlast[0]     = (q0.size() > 0) && q0[0][32];
      s_tvalid[1]    = q1.size() > 0;
      s_tdata[63:32] = (q1.size() > 0) ? q1[0][31:0] : '0;
      s_tlast[1]     = (q1.size() > 0) && q1[0][32];
   endtask

   task automatic src_word(input int src, input logic [31:0] d, input logic last);
      if (src == 0) q0.push_back({last, d});
      else          q1.push_back({last, d});
      present();
   endtask

   task automatic src_pkt(input int src, input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) src_word(src, base + 32'(k), k == n - 1);
   endtask

   task automatic exp_pkt(input int src, input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({3'(src), k == n - 1, base + 32'(k)});
   endtask

   // One clock: score outputs at the falling edge, advance sources after the rising edge
   task automatic step();
      logic [NS-1:0] hs;
      logic [35:0]   e;
      @(negedge clk);
      cyc++;
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
         beats++;
         prev_beat_cyc = last_beat_cyc;
         last_beat_cyc = cyc;
         if (exp_q.size() == 0) chk("unexpected_beat", 64'(m_tvalid), 64'(0));
         else begin
            e = exp_q.pop_front();
            chk("m_tdata", 64'(m_tdata), 64'(e[31:0]));
            chk("m_tlast", 64'(m_tlast), 64'(e[32]));
            chk("grantIndex", 64'(grant_index), 64'(e[35:33]));
         end
      end
      if (status_strobe) begin
         prev_strobe_cyc = last_strobe_cyc;
         last_strobe_cyc = cyc;
         if (stat_q.size() == 0) chk("unexpected_strobe", 64'(status_strobe), 64'(0));
         else chk("statusCode", 64'(status_code), 64'(stat_q.pop_front()));
      end
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      present();
   endtask

   // Run until expectations and the selected source queues are consumed
   task automatic run_idle(input string tag, input logic [1:0] wmask, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || stat_q.size() != 0 ||
              (wmask[0] && q0.size() != 0) || (wmask[1] && q1.size() != 0)) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(n < budget), 64'(1));
      repeat (3) step();
   endtask

   task automatic wait_beats(input int target);
      int n = 0;
      while (beats < target && n < 40) begin
         step();
         n++;
      end
      chk("wait_beats", 64'(beats), 64'(target));
   endtask

   task automatic pulse_fa();
      fa = 1'b1;
      step();
      fa = 1'b0;
   endtask

   initial begin
      int b;
      rst_n = 1'b0; chan = 1'b0; fa = 1'b0; m_tready = 1'b0; en = '1;
      present();
      #12;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      chk("rst_m_tdata", 64'(m_tdata), 64'(0));
      chk("rst_s_tready", 64'(s_tready), 64'(0));
      chk("rst_grantIndex", 64'(grant_index), 64'(0));
      chk("rst_strobe", 64'(status_strobe), 64'(0));
      chk("rst_packetCount", 64'(packet_count), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; chan = 1'b1; m_tready = 1'b1;

      // Single source, fixed 4-word packet
      src_word(0, 32'hA5BE0000, 1'b0); src_word(0, 32'hCAFE0001, 1'b0);
      src_word(0, 32'hBEEF0001, 1'b0); src_word(0, 32'h00010001, 1'b1);
      exp_q.push_back({3'd0, 1'b0, 32'hA5BE0000}); exp_q.push_back({3'd0, 1'b0, 32'hCAFE0001});
      exp_q.push_back({3'd0, 1'b0, 32'hBEEF0001}); exp_q.push_back({3'd0, 1'b1, 32'h00010001});
      stat_q.push_back(2'd0);
      run_idle("t1_done", 2'b11, 30);
      chk("t1_packetCount", 64'(packet_count), 64'(1));
      chk("t1_grantIndex", 64'(grant_index), 64'(0));

      // Both sources busy; pointer sits at 0 so source 1 goes first, then alternate
      pulse_fa();
      chk("t2_fa_clear", 64'(packet_count), 64'(0));
      src_pkt(1, 32'h1100_0000, 4); exp_pkt(1, 32'h1100_0000, 4);
      src_pkt(0, 32'h0000_1000, 4); exp_pkt(0, 32'h0000_1000, 4);
      src_pkt(1, 32'h1100_0100, 4); exp_pkt(1, 32'h1100_0100, 4);
      src_pkt(0, 32'h0000_1100, 4); exp_pkt(0, 32'h0000_1100, 4);
      repeat (4) stat_q.push_back(2'd0);
      b = cyc;
      run_idle("t2_done", 2'b11, 60);
      chk("t2_packetCount", 64'(packet_count), 64'(4));
      // 4 packets x (1 arbitration + 4 beats): last beat lands 20 cycles in
      chk("t2_idle_gaps", 64'(last_beat_cyc - b), 64'(20));

      // Timeout: source 1 stalls after two words
      src_word(1, 32'h2222_0001, 1'b0); src_word(1, 32'h2222_0002, 1'b0);
      exp_q.push_back({3'd1, 1'b0, 32'h2222_0001}); exp_q.push_back({3'd1, 1'b0, 32'h2222_0002});
      exp_q.push_back({3'd1, 1'b1, 32'hDEADDEAD});
      stat_q.push_back(2'd3);
      run_idle("t3_close", 2'b11, 40);
      chk("t3_timeout_gap", 64'(last_beat_cyc - prev_beat_cyc), 64'(TO + 1));
      src_word(1, 32'h2222_0003, 1'b0); src_word(1, 32'h2222_0004, 1'b1);
      run_idle("t3_drain", 2'b11, 20);
      src_pkt(0, 32'h3000_0000, 2); exp_pkt(0, 32'h3000_0000, 2);
      src_pkt(1, 32'h3100_0000, 2); exp_pkt(1, 32'h3100_0000, 2);
      stat_q.push_back(2'd0); stat_q.push_back(2'd0);
      run_idle("t3_after", 2'b11, 30);

      // Disabled source is never granted
      en[1] = 1'b0;
      src_pkt(1, 32'h4100_0000, 4);
      src_pkt(0, 32'h4000_0000, 4); exp_pkt(0, 32'h4000_0000, 4);
      stat_q.push_back(2'd0);
      run_idle("t4_src0", 2'b01, 30);
      repeat (3) step();
      chk("t4_disabled_waits", 64'(q1.size()), 64'(4));
      en[1] = 1'b1;
      exp_pkt(1, 32'h4100_0000, 4);
      stat_q.push_back(2'd0);
      run_idle("t4_src1", 2'b11, 30);

      // Channel drop after first word
      b = beats;
      src_pkt(0, 32'h5000_0000, 4);
      exp_q.push_back({3'd0, 1'b0, 32'h5000_0000});
      stat_q.push_back(2'd2);
      wait_beats(b + 1);
      chan = 1'b0;
      src_pkt(1, 32'h5100_0000, 4);
      run_idle("t5_drain", 2'b01, 20);
      repeat (3) step();
      chk("t5_no_grant", 64'(q1.size()), 64'(4));
      chk("t5_m_tvalid_low", 64'(m_tvalid), 64'(0));
      chan = 1'b1;
      exp_pkt(1, 32'h5100_0000, 4);
      stat_q.push_back(2'd0);
      run_idle("t5_resume", 2'b11, 30);

      // FA strobe mid-packet with five packets counted
      pulse_fa();
      for (int k = 0; k < 5; k++) begin
         src_pkt(0, 32'h6000_0000 + 32'(k), 1); exp_pkt(0, 32'h6000_0000 + 32'(k), 1);
         stat_q.push_back(2'd0);
      end
      run_idle("t6_five", 2'b11, 40);
      chk("t6_count5", 64'(packet_count), 64'(5));
      b = beats;
      src_pkt(0, 32'h6100_0000, 4); exp_pkt(0, 32'h6100_0000, 4);
      stat_q.push_back(2'd1); stat_q.push_back(2'd0);
      wait_beats(b + 2);
      pulse_fa();
      chk("t6_fa_cleared", 64'(packet_count), 64'(0));
      run_idle("t6_mid", 2'b11, 30);
      chk("t6_count1", 64'(packet_count), 64'(1));

      // FA strobe on the tlast handshake: done first, FA report one cycle later
      b = beats;
      src_pkt(0, 32'h6200_0000, 4); exp_pkt(0, 32'h6200_0000, 4);
      stat_q.push_back(2'd0); stat_q.push_back(2'd1);
      wait_beats(b + 3);
      pulse_fa();
      run_idle("t6_coincide", 2'b11, 30);
      chk("t6_strobe_gap", 64'(last_strobe_cyc - prev_strobe_cyc), 64'(1));
      chk("t6_increment_lost", 64'(packet_count), 64'(0));

      // Asynchronous reset mid-packet with the link stalled; pointer is 0 so source 1 holds the grant
      m_tready = 1'b0;
      src_pkt(0, 32'h7000_0000, 4);
      src_pkt(1, 32'h7100_0000, 4);
      repeat (3) step();
      chk("t7_pre_grant", 64'(grant_index), 64'(1));
      chk("t7_pre_valid", 64'(m_tvalid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_m_tvalid", 64'(m_tvalid), 64'(0));
      chk("t7_rst_m_tdata", 64'(m_tdata), 64'(0));
      chk("t7_rst_m_tlast", 64'(m_tlast), 64'(0));
      chk("t7_rst_s_tready", 64'(s_tready), 64'(0));
      chk("t7_rst_grant", 64'(grant_index), 64'(0));
      q0.delete(); q1.delete(); exp_q.delete(); stat_q.delete();
      present();
      @(posedge clk); #1;
      rst_n = 1'b1; m_tready = 1'b1;
      src_pkt(1, 32'h7300_0000, 2);
      src_pkt(0, 32'h7200_0000, 2);
      exp_pkt(0, 32'h7200_0000, 2); exp_pkt(1, 32'h7300_0000, 2);
      stat_q.push_back(2'd0); stat_q.push_back(2'd0);
      run_idle("t7_after", 2'b11, 30);
      chk("t7_count", 64'(packet_count), 64'(2));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
